key_buffer_fifo: RTL and testbench

Parametrised synchronous FIFO that buffers N-bit key codes between the keypad decoder, which produces one `push` pulse per detected key, and the downstream consumer (display/control logic), which drains codes with `pop`. It generalises the single load-enabled register to a DEPTH-entry queue with first-word-fall-through output. It also provides occupancy count, full/empty status and sticky overflow/underflow error flags.

---
 rtl/key_buffer_fifo.sv | 99 +++++++++
 tb/tb_key_buffer_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_buffer_fifo.sv
// key_buffer_fifo: DEPTH-entry first-word-fall-through queue for key codes.
// Sits between the keypad decoder (one push pulse per key) and the consumer
// (display/control), and reports occupancy plus sticky overflow/underflow errors.
//
// Handshake: push and pop are level-sampled on every rising edge. The producer
// may push while full only if a pop is accepted in the same cycle, otherwise the
// word is dropped and ovf latches. A pop while empty is ignored and udf latches.
// Callers drive single-cycle pulses: a level held for M cycles is M operations.
module key_buffer_fifo #(
    parameter int N = 5,
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [N-1:0] d_in,
    input  logic         pop,
    output logic [N-1:0] d_out,
    output logic         empty,
    output logic         full,
    output logic [A:0]   count,
    output logic         ovf,
    output logic         udf
);

    localparam int         DEPTH     = 2 ** A;
    localparam logic [A:0] DEPTH_CNT = (A + 1)'(DEPTH);

    logic [N-1:0] mem [DEPTH];
    logic [A-1:0] wp;
    logic [A-1:0] rp;

    logic         push_ok;
    logic         pop_ok;
    logic [A:0]   count_nxt;

    // Status is decoded from the registered occupancy count.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // Head entry is shown directly from storage; zero when nothing is queued.
    assign d_out = empty ? '0 : mem[rp];

    // Accept decisions: a full queue still takes a push when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    // Occupancy update: simultaneous accepted push and pop cancel out.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + (A + 1)'(1);
            2'b01:   count_nxt = count - (A + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage write; the array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!clr && push_ok) begin
            mem[wp] <= d_in;
        end
    end

    // Pointers, count and sticky error flags; clr takes priority over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= wp + A'(1);
            end
            if (pop_ok) begin
                rp <= rp + A'(1);
            end
            count <= count_nxt;
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end
            if (pop && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_buffer_fifo.sv
// Testbench for key_buffer_fifo with default parameters (N=5, DEPTH=8).
// Directed vector table for the single-cycle behaviour, plus hand-written
// sequences for pointer wrap-around and asynchronous reset mid-cycle.
module tb_key_buffer_fifo;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       push;
    logic [4:0] d_in;
    logic       pop;
    logic [4:0] d_out;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [4:0] d_in;
        logic [3:0] count;
        logic       empty;
        logic       full;
        logic [4:0] d_out;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];
    logic [4:0] exp_q[$];

    key_buffer_fifo #(.N(5), .A(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .d_in  (d_in),
        .pop   (pop),
        .d_out (d_out),
        .empty (empty),
        .full  (full),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic p_push, logic p_pop, logic p_clr, logic [4:0] p_din,
                                logic [3:0] e_count, logic e_empty, logic e_full,
                                logic [4:0] e_dout, logic e_ovf, logic e_udf);
        vec_t v;
        v.push  = p_push;
        v.pop   = p_pop;
        v.clr   = p_clr;
        v.d_in  = p_din;
        v.count = e_count;
        v.empty = e_empty;
        v.full  = e_full;
        v.d_out = e_dout;
        v.ovf   = e_ovf;
        v.udf   = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_count, input logic e_empty,
                           input logic e_full, input logic [4:0] e_dout,
                           input logic e_ovf, input logic e_udf);
        chk({tag, ".count"}, 32'(count), 32'(e_count));
        chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
        chk({tag, ".full"},  32'(full),  32'(e_full));
        chk({tag, ".d_out"}, 32'(d_out), 32'(e_dout));
        chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
        chk({tag, ".udf"},   32'(udf),   32'(e_udf));
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 unit after the rising edge.
    task automatic cycle(input logic p_push, input logic p_pop, input logic p_clr, input logic [4:0] p_din);
        @(negedge clk);
        push = p_push;
        pop  = p_pop;
        clr  = p_clr;
        d_in = p_din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        d_in = '0;
    endtask

    initial begin
        // Reset state
        rst  = 1'b1;
        clr  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        d_in = '0;
        #2;
        chk_all("reset", 4'd0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic order: push 01,02,03 then drain
        vecs.push_back(mk(1, 0, 0, 5'h01, 4'd1, 0, 0, 5'h01, 0, 0));
        vecs.push_back(mk(1, 0, 0, 5'h02, 4'd2, 0, 0, 5'h01, 0, 0));
        vecs.push_back(mk(1, 0, 0, 5'h03, 4'd3, 0, 0, 5'h01, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd2, 0, 0, 5'h02, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd1, 0, 0, 5'h03, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd0, 1, 0, 5'h00, 0, 0));
        // Fill with 10..17, overflow push of 1F, then drain in order
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 0, 5'(5'h10 + i), 4'(i + 1), 0, (i == 7), 5'h10, 0, 0));
        vecs.push_back(mk(1, 0, 0, 5'h1F, 4'd8, 0, 1, 5'h10, 1, 0));
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(0, 1, 0, 5'h00, 4'(8 - i), 0, 0, 5'(5'h10 + i), 1, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd0, 1, 0, 5'h00, 1, 0));
        // Refill with 08..0F, then push+pop while full with 1A, then drain
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 0, 5'(5'h08 + i), 4'(i + 1), 0, (i == 7), 5'h08, 1, 0));
        vecs.push_back(mk(1, 1, 0, 5'h1A, 4'd8, 0, 1, 5'h09, 1, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 1, 0, 5'h00, 4'(7 - i), 0, 0, 5'(5'h0A + i), 1, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd1, 0, 0, 5'h1A, 1, 0));
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd0, 1, 0, 5'h00, 1, 0));
        // Underflow, then push+pop on empty
        vecs.push_back(mk(0, 1, 0, 5'h00, 4'd0, 1, 0, 5'h00, 1, 1));
        vecs.push_back(mk(1, 1, 0, 5'h05, 4'd1, 0, 0, 5'h05, 1, 1));
        // Build up to 4 entries, then clr together with push
        vecs.push_back(mk(1, 0, 0, 5'h06, 4'd2, 0, 0, 5'h05, 1, 1));
        vecs.push_back(mk(1, 0, 0, 5'h07, 4'd3, 0, 0, 5'h05, 1, 1));
        vecs.push_back(mk(1, 0, 0, 5'h08, 4'd4, 0, 0, 5'h05, 1, 1));
        vecs.push_back(mk(1, 0, 1, 5'h1F, 4'd0, 1, 0, 5'h00, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].d_in);
            chk_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].empty, vecs[i].full,
                    vecs[i].d_out, vecs[i].ovf, vecs[i].udf);
        end

        // Wrap-around: 20 cycles of interleaved traffic, occupancy kept in 1..3
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic do_push;
            logic do_pop;
            logic [4:0] w;
            w = 5'((i * 7 + 3) % 32);
            if (i < 2) begin
                do_push = 1'b1;
                do_pop  = 1'b0;
            end else if (i % 2 == 0) begin
                do_push = 1'b1;
                do_pop  = 1'b1;
            end else if (exp_q.size() <= 1) begin
                do_push = 1'b1;
                do_pop  = 1'b0;
            end else begin
                do_push = 1'b0;
                do_pop  = 1'b1;
            end
            cycle(do_push, do_pop, 1'b0, w);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(w);
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'(exp_q.size()));
            chk($sformatf("wrap%0d.d_out", i), 32'(d_out), 32'(exp_q[0]));
            chk($sformatf("wrap%0d.err", i), 32'({ovf, udf}), 32'(0));
        end
        // Drain and confirm the tail of the order
        while (exp_q.size() > 0) begin
            cycle(1'b0, 1'b1, 1'b0, 5'h00);
            void'(exp_q.pop_front());
            chk("drain.d_out", 32'(d_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'(0));
        end
        chk("drain.empty", 32'(empty), 32'(1));

        // Asynchronous reset mid-cycle with two entries held
        cycle(1'b1, 1'b0, 1'b0, 5'h11);
        cycle(1'b1, 1'b0, 1'b0, 5'h12);
        idle_inputs();
        chk_all("two_held", 4'd2, 1'b0, 1'b0, 5'h11, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 5'h13);
        chk_all("after_rst", 4'd1, 1'b0, 1'b0, 5'h13, 1'b0, 1'b0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
